// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;
  localparam int CNT_W       = 16;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - combinational 2-way round-robin chooser
module rr_pick2 (
  input  logic [1:0] active,
  input  logic       prio,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |active;
    grant_idx   = 1'b0;
    // prio only matters on contention; a lone requester always wins
    if (&active) begin
      grant_idx = prio;
    end else begin
      grant_idx = active[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between two requesters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_read_en,
  input  logic              req0_write_en,
  input  logic [DATA_W-1:0] req0_write_val,
  output logic [DATA_W-1:0] req0_read_val,
  output logic              req0_response,
  output logic              req0_error,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_read_en,
  input  logic              req1_write_en,
  input  logic [DATA_W-1:0] req1_write_val,
  output logic [DATA_W-1:0] req1_read_val,
  output logic              req1_response,
  output logic              req1_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_val,
  input  logic [DATA_W-1:0] mem_read_val,
  input  logic              mem_response
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               re_q, re_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wv_q, wv_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;

  logic [1:0]         active;
  logic               grant_valid;
  logic               grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wv;
  logic               sel_re;
  logic               sel_we;
  logic               resp_active;

  assign active = {req1_read_en | req1_write_en, req0_read_en | req0_write_en};

  rr_pick2 u_pick (
    .active      (active),
    .prio        (prio_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_addr = grant_idx ? req1_addr      : req0_addr;
  assign sel_wv   = grant_idx ? req1_write_val : req0_write_val;
  assign sel_re   = grant_idx ? req1_read_en   : req0_read_en;
  assign sel_we   = grant_idx ? req1_write_en  : req0_write_en;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    re_d    = re_q;
    we_d    = we_q;
    wv_d    = wv_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          gnt_d   = grant_idx;
          addr_d  = sel_addr;
          wv_d    = sel_wv;
          we_d    = sel_we;
          re_d    = sel_re & ~sel_we;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // a response arriving on the watchdog's last cycle still completes cleanly
        if (mem_response) begin
          data_d  = re_q ? mem_read_val : '0;
          err_d   = 1'b0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          data_d  = DATA_W'(ERR_DATA);
          err_d   = 1'b1;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        prio_d  = ~gnt_q;
        data_d  = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wv_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wv_q    <= wv_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_read_en   = re_q;
  assign mem_write_en  = we_q;
  assign mem_write_val = wv_q;

  assign resp_active   = (state_q == ST_RESP);
  assign req0_response = resp_active & ~gnt_q;
  assign req1_response = resp_active &  gnt_q;
  assign req0_read_val = req0_response ? data_q : '0;
  assign req1_read_val = req1_response ? data_q : '0;
  assign req0_error    = req0_response & err_q;
  assign req1_error    = req1_response & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req0_addr, req0_write_val, req1_addr, req1_write_val, mem_read_val;
  logic        req0_read_en, req0_write_en, req1_read_en, req1_write_en, mem_response;

  logic [31:0] req0_read_val, req1_read_val, mem_addr, mem_write_val;
  logic        req0_response, req0_error, req1_response, req1_error, mem_read_en, mem_write_en;
  logic [31:0] t_req0_read_val, t_req1_read_val, t_mem_addr, t_mem_write_val;
  logic        t_req0_response, t_req0_error, t_req1_response, t_req1_error;
  logic        t_mem_read_en, t_mem_write_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] tmem [logic [31:0]];
  logic [31:0] mref [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_addr(req0_addr), .req0_read_en(req0_read_en), .req0_write_en(req0_write_en),
    .req0_write_val(req0_write_val), .req0_read_val(req0_read_val),
    .req0_response(req0_response), .req0_error(req0_error),
    .req1_addr(req1_addr), .req1_read_en(req1_read_en), .req1_write_en(req1_write_en),
    .req1_write_val(req1_write_val), .req1_read_val(req1_read_val),
    .req1_response(req1_response), .req1_error(req1_error),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val), .mem_response(mem_response)
  );

  mem_arbiter #(.TIMEOUT(4)) u_to (
    .clk(clk), .reset(reset),
    .req0_addr(req0_addr), .req0_read_en(req0_read_en), .req0_write_en(req0_write_en),
    .req0_write_val(req0_write_val), .req0_read_val(t_req0_read_val),
    .req0_response(t_req0_response), .req0_error(t_req0_error),
    .req1_addr(req1_addr), .req1_read_en(req1_read_en), .req1_write_en(req1_write_en),
    .req1_write_val(req1_write_val), .req1_read_val(t_req1_read_val),
    .req1_response(t_req1_response), .req1_error(t_req1_error),
    .mem_addr(t_mem_addr), .mem_read_en(t_mem_read_en), .mem_write_en(t_mem_write_en),
    .mem_write_val(t_mem_write_val), .mem_read_val(mem_read_val), .mem_response(mem_response)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C3C, 16'hA55A};
  endfunction

  task automatic clear_reqs();
    req0_addr = '0; req0_read_en = 0; req0_write_en = 0; req0_write_val = '0;
    req1_addr = '0; req1_read_en = 0; req1_write_en = 0; req1_write_val = '0;
    mem_response = 0; mem_read_val = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_reqs();
    tmem.delete();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // Memory-side responder: waits for a strobe, holds delay BUSY cycles, then acknowledges.
  task automatic serve(input int delay, output int wait_cyc, output logic [1:0] rsp,
                       output logic [31:0] a, output logic w, output logic r,
                       output logic [31:0] wv, output bit stable, output logic [31:0] rv,
                       output logic er, output bit quiet_other, output bit one_cycle);
    bit got;
    got = 0; wait_cyc = 0; rsp = 0; a = 0; w = 0; r = 0; wv = 0;
    stable = 0; rv = 0; er = 0; quiet_other = 0; one_cycle = 0;
    while (!got && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
      got = mem_read_en | mem_write_en;
    end
    if (!got) return;
    a = mem_addr; w = mem_write_en; r = mem_read_en; wv = mem_write_val; stable = 1;
    repeat (delay) begin
      @(negedge clk);
      if (mem_addr !== a || mem_write_en !== w || mem_read_en !== r ||
          mem_write_val !== wv || req0_response || req1_response) stable = 0;
    end
    if (w) tmem[a] = wv;
    mem_read_val = r ? (tmem.exists(a) ? tmem[a] : dflt(a)) : $urandom;
    mem_response = 1;
    @(negedge clk);
    mem_response = 0;
    mem_read_val = $urandom;
    rsp = {req1_response, req0_response};
    if (rsp == 2'b01) begin
      rv = req0_read_val; er = req0_error;
      quiet_other = (req1_read_val === '0) && (req1_error === 1'b0);
      req0_read_en = 0; req0_write_en = 0;
    end else if (rsp == 2'b10) begin
      rv = req1_read_val; er = req1_error;
      quiet_other = (req0_read_val === '0) && (req0_error === 1'b0);
      req1_read_en = 0; req1_write_en = 0;
    end
    @(negedge clk);
    one_cycle = !(req0_response || req1_response);
  endtask

  task automatic test_reset();
    reset = 0;
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_write_val, req0_read_val, req1_read_val} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h exp 0", mem_addr, mem_write_val, req0_read_val, req1_read_val);
    end
    checks++;
    if ({mem_read_en, mem_write_en, req0_response, req0_error, req1_response, req1_error} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 000000",
        {mem_read_en, mem_write_en, req0_response, req0_error, req1_response, req1_error});
    end
    reset = 1;
  endtask

  task automatic test_single_read();
    do_reset();
    req0_addr = 32'h10; req0_read_en = 1;
    @(negedge clk);
    checks++;
    if ({mem_read_en, mem_write_en, mem_addr} !== {2'b10, 32'h10}) begin
      errors++; $display("FAIL single_issue: got re=%b we=%b addr=%h exp re=1 we=0 addr=10", mem_read_en, mem_write_en, mem_addr);
    end
    mem_response = 1; mem_read_val = 32'hCAFEF00D;
    @(negedge clk);
    mem_response = 0; mem_read_val = '0;
    checks++;
    if ({req0_response, req0_error, req0_read_val} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL single_resp: got rsp=%b err=%b rv=%h exp 1 0 cafef00d", req0_response, req0_error, req0_read_val);
    end
    checks++;
    if ({req1_response, req1_error, req1_read_val} !== '0) begin
      errors++; $display("FAIL single_other: got %b %b %h exp 0", req1_response, req1_error, req1_read_val);
    end
    req0_read_en = 0;
    @(negedge clk);
    checks++;
    if (req0_response !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got %b exp 0", req0_response);
    end
  endtask

  task automatic test_simultaneous();
    int wc; logic [1:0] rsp; logic [31:0] a, wv, rv; logic w, r, er; bit st, qo, oc;
    reset = 0;
    clear_reqs();
    tmem.delete();
    req0_addr = 32'h20; req0_write_en = 1; req0_write_val = 32'h11;
    req1_addr = 32'h24; req1_read_en = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    serve(1, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
    checks++;
    if ({rsp, a, w, wv} !== {2'b01, 32'h20, 1'b1, 32'h11}) begin
      errors++; $display("FAIL simul_first: got rsp=%b addr=%h we=%b wv=%h exp 01 20 1 11", rsp, a, w, wv);
    end
    serve(0, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
    checks++;
    if ({rsp, a, r, rv} !== {2'b10, 32'h24, 1'b1, dflt(32'h24)}) begin
      errors++; $display("FAIL simul_second: got rsp=%b addr=%h re=%b rv=%h exp 10 24 1 %h", rsp, a, r, rv, dflt(32'h24));
    end
  endtask

  task automatic test_fairness();
    int wc; logic [1:0] rsp; logic [31:0] a, wv, rv; logic w, r, er; bit st, qo, oc;
    do_reset();
    req0_addr = 32'h50; req0_read_en = 1;
    req1_addr = 32'h54; req1_read_en = 1;
    for (int i = 0; i < 6; i++) begin
      serve(0, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
      checks++;
      if (rsp !== ((i % 2) ? 2'b10 : 2'b01) || wc != 1 || !oc || !qo) begin
        errors++; $display("FAIL fair_%0d: got rsp=%b wait=%0d pulse_ok=%0d other_ok=%0d exp rsp=%b wait=1 1 1",
          i, rsp, wc, oc, qo, (i % 2) ? 2'b10 : 2'b01);
      end
      req0_read_en = 1;
      req1_read_en = 1;
    end
  endtask

  task automatic test_rw_slow();
    int wc; logic [1:0] rsp; logic [31:0] a, wv, rv; logic w, r, er; bit st, qo, oc;
    do_reset();
    req0_addr = 32'h30; req0_read_en = 1; req0_write_en = 1; req0_write_val = 32'h12345678;
    serve(5, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
    checks++;
    if ({rsp, w, r, wv} !== {2'b01, 1'b1, 1'b0, 32'h12345678}) begin
      errors++; $display("FAIL rw_issue: got rsp=%b we=%b re=%b wv=%h exp 01 1 0 12345678", rsp, w, r, wv);
    end
    checks++;
    if (!st || !oc || rv !== '0 || er !== 1'b0) begin
      errors++; $display("FAIL rw_slow: got stable=%0d pulse_ok=%0d rv=%h err=%b exp 1 1 0 0", st, oc, rv, er);
    end
  endtask

  task automatic test_timeout();
    int k_to, k_main; logic [31:0] t_rv, m_rv; logic t_er, m_er; bit t_quiet;
    do_reset();
    req1_addr = 32'h40; req1_read_en = 1;
    @(negedge clk);
    checks++;
    if (t_mem_read_en !== 1'b1) begin
      errors++; $display("FAIL to_issue: got %b exp 1", t_mem_read_en);
    end
    k_to = -1; k_main = -1; t_rv = 0; m_rv = 0; t_er = 0; m_er = 0; t_quiet = 0;
    for (int k = 1; k <= 300 && k_main < 0; k++) begin
      @(negedge clk);
      if (t_req1_response && k_to < 0) begin
        k_to = k; t_rv = t_req1_read_val; t_er = t_req1_error;
        t_quiet = !t_req0_response && !t_req0_error && (t_req0_read_val === '0);
        req1_read_en = 0;
      end
      if (req1_response) begin
        k_main = k; m_rv = req1_read_val; m_er = req1_error;
      end
    end
    checks++;
    if (k_to != 4 || t_er !== 1'b1 || t_rv !== 32'hDEADBEEF || !t_quiet) begin
      errors++; $display("FAIL to_short: got cyc=%0d err=%b rv=%h other_ok=%0d exp 4 1 deadbeef 1", k_to, t_er, t_rv, t_quiet);
    end
    checks++;
    if (k_main != 255 || m_er !== 1'b1 || m_rv !== 32'hDEADBEEF) begin
      errors++; $display("FAIL to_default: got cyc=%0d err=%b rv=%h exp 255 1 deadbeef", k_main, m_er, m_rv);
    end
    @(negedge clk);
    req0_addr = 32'h44; req0_read_en = 1;
    @(negedge clk);
    mem_response = 1; mem_read_val = 32'h600DF00D;
    @(negedge clk);
    mem_response = 0;
    checks++;
    if ({t_req0_response, t_req0_error, t_req0_read_val, req0_response, req0_error, req0_read_val}
        !== {2'b10, 32'h600DF00D, 2'b10, 32'h600DF00D}) begin
      errors++; $display("FAIL to_next: got %b %b %h / %b %b %h exp 1 0 600df00d both",
        t_req0_response, t_req0_error, t_req0_read_val, req0_response, req0_error, req0_read_val);
    end
    req0_read_en = 0;
    @(negedge clk);
    req0_addr = 32'h48; req0_read_en = 1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    mem_response = 1; mem_read_val = 32'h7E57DA7A;
    @(negedge clk);
    mem_response = 0;
    checks++;
    if ({t_req0_response, t_req0_error, t_req0_read_val} !== {2'b10, 32'h7E57DA7A}) begin
      errors++; $display("FAIL to_tie: got rsp=%b err=%b rv=%h exp 1 0 7e57da7a", t_req0_response, t_req0_error, t_req0_read_val);
    end
    req0_read_en = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int wc; logic [1:0] rsp; logic [31:0] a, wv, rv; logic w, r, er; bit st, qo, oc, quiet;
    do_reset();
    req0_addr = 32'h58; req0_read_en = 1;
    serve(0, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
    req1_addr = 32'h60; req1_write_en = 1; req1_write_val = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if ({rsp, mem_write_en} !== 3'b011) begin
      errors++; $display("FAIL mid_setup: got rsp=%b we=%b exp 01 1", rsp, mem_write_en);
    end
    @(posedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if ({mem_addr, mem_write_val, mem_write_en, mem_read_en, req1_response, req0_response} !== '0) begin
      errors++; $display("FAIL mid_async: got addr=%h wv=%h we=%b re=%b exp all 0", mem_addr, mem_write_val, mem_write_en, mem_read_en);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    reset = 1;
    quiet = 1;
    repeat (5) begin
      @(negedge clk);
      if (req0_response || req1_response || mem_read_en || mem_write_en) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL mid_quiet: got activity=1 exp 0");
    end
    req0_addr = 32'h64; req0_read_en = 1;
    req1_addr = 32'h68; req1_read_en = 1;
    serve(0, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
    checks++;
    if (rsp !== 2'b01 || a !== 32'h64) begin
      errors++; $display("FAIL mid_prio: got rsp=%b addr=%h exp 01 64", rsp, a);
    end
    serve(0, wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
  endtask

  task automatic test_random();
    int wc, prio_m, g, op; logic [1:0] rsp; logic [31:0] a, wv, rv, exp_rv; logic w, r, er; bit st, qo, oc;
    bit act [2]; bit rdq [2]; bit wrq [2]; logic [31:0] ad [2]; logic [31:0] dv [2];
    do_reset();
    mref.delete();
    prio_m = 0;
    for (int n = 0; n < 2; n++) begin act[n] = 0; rdq[n] = 0; wrq[n] = 0; ad[n] = 0; dv[n] = 0; end
    for (int it = 0; it < 24; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 3) != 0) begin
          act[n] = 1;
          ad[n] = 32'h100 + 32'(4 * $urandom_range(0, 3));
          dv[n] = $urandom;
          op = $urandom_range(0, 2);
          rdq[n] = (op != 1);
          wrq[n] = (op != 0);
        end
      end
      if (!act[0] && !act[1]) begin
        act[0] = 1; ad[0] = 32'h104; dv[0] = $urandom; rdq[0] = 1; wrq[0] = 0;
      end
      req0_addr = ad[0]; req0_write_val = dv[0]; req0_read_en = act[0] & rdq[0]; req0_write_en = act[0] & wrq[0];
      req1_addr = ad[1]; req1_write_val = dv[1]; req1_read_en = act[1] & rdq[1]; req1_write_en = act[1] & wrq[1];
      g = (act[0] && act[1]) ? prio_m : (act[0] ? 0 : 1);
      exp_rv = wrq[g] ? 32'h0 : (mref.exists(ad[g]) ? mref[ad[g]] : dflt(ad[g]));
      serve($urandom_range(0, 4), wc, rsp, a, w, r, wv, st, rv, er, qo, oc);
      checks++;
      if (rsp !== ((g == 1) ? 2'b10 : 2'b01) || a !== ad[g] || w !== wrq[g] ||
          r !== (rdq[g] && !wrq[g]) || wv !== dv[g]) begin
        errors++; $display("FAIL rand_issue_%0d: got rsp=%b addr=%h we=%b re=%b wv=%h exp grant=%0d addr=%h we=%b re=%b wv=%h",
          it, rsp, a, w, r, wv, g, ad[g], wrq[g], rdq[g] && !wrq[g], dv[g]);
      end
      checks++;
      if (rv !== exp_rv || er !== 1'b0 || !st || !qo || !oc) begin
        errors++; $display("FAIL rand_resp_%0d: got rv=%h err=%b stable=%0d other_ok=%0d pulse_ok=%0d exp rv=%h 0 1 1 1",
          it, rv, er, st, qo, oc, exp_rv);
      end
      if (wrq[g]) mref[ad[g]] = dv[g];
      prio_m = 1 - g;
      act[g] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout: got no finish exp finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_rw_slow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single TemporaryMemory port between two requesters, for example Core instruction fetch and Core data access, or two Cores. It uses round-robin scheduling. It sits between the requesters and the memory, reusing the memory-side signal set (addr / write_en / read_en / write_val / read_val / response) on both sides. Each access is a registered, single-outstanding transaction: issue, wait for `mem_response`, then return a one-cycle response pulse to the granted requester. A watchdog terminates accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max BUSY cycles before forced error completion; 0 disables the watchdog
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- reqN_addr  in  ADDR_W  requester N address, N = 0, 1
- reqN_read_en  in  1  requester N read request; held until reqN_response
- reqN_write_en  in  1  requester N write request; held until reqN_response
- reqN_write_val  in  DATA_W  requester N write data; held until reqN_response
- reqN_read_val  out  DATA_W  read data; valid only while reqN_response=1
- reqN_response  out  1  one-cycle completion pulse
- reqN_error  out  1  qualifies reqN_response: access timed out
- mem_addr  out  ADDR_W  registered address to memory
- mem_read_en  out  1  registered read strobe
- mem_write_en  out  1  registered write strobe
- mem_write_val  out  DATA_W  registered write data
- mem_read_val  in  DATA_W  memory read data, sampled when mem_response=1
- mem_response  in  1  memory completion

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - A requester is active if its read_en or write_en is 1.
  - If both requesters are active, grant the one selected by priority pointer `prio`; otherwise grant the single active one.
  - On grant, register addr, write_val, read_en and write_en into the mem_* outputs, store the grant index, clear the watchdog counter, and go to BUSY.
  - If read_en and write_en are both 1 on one requester, it is a write: mem_read_en=0.
- **BUSY**
  - mem_* outputs are held constant.
  - If mem_response=1: capture mem_read_val (0 for writes), clear mem_*_en, go to RESP.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: capture 32'hDEADBEEF, set error, clear mem_*_en, go to RESP.
  - Otherwise increment the 16-bit saturating counter.
- **RESP**
  - Granted reqN_response=1 for exactly one cycle; reqN_read_val = captured data; reqN_error = timeout flag.
  - `prio` becomes the non-granted index.
  - Go to IDLE.
  - The other requester's outputs stay 0.
- The requester must deassert its enables in the cycle after seeing response; IDLE then cannot re-grant the same stale request.
- A request dropped before its response is a protocol violation: the arbiter completes the access anyway.
- When reset is asserted: state=IDLE, prio=0, all outputs 0 (mem_addr, mem_write_val, reqN_read_val = 0), counter=0. This holds when reset is asserted mid-transaction. The in-flight access is abandoned and no response is issued.

## Timing
- Request first seen in IDLE at cycle T → mem_*_en=1 at T+1.
- mem_response=1 in cycle M≥T+1 → reqN_response at M+1 → IDLE at M+2.
- Minimum latency is 2 cycles request-to-response; back-to-back grants are 3 cycles apart.
- mem_response is ignored outside BUSY.
- mem_response in the same cycle as the timeout hit: the response wins and error=0.
- With both requesters continuously active, grants strictly alternate. Worst-case wait is one full transaction of the other requester.
- All outputs are driven from flops; there is no combinational path input→output.

## Structure
- Shared include file (MemDefs.vh): FSM state encodings, ADDR_W/DATA_W defaults, ERR_DATA 32'hDEADBEEF, the watchdog counter width (16).
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin chooser with inputs active[1:0] and prio, and outputs grant_valid and grant_idx.
- Top-level Processor instantiates mem_arbiter between Core ports and TemporaryMemory.

## Test plan
- Single read: req0 read addr 0x10, memory returns 0xCAFEF00D with response 1 cycle after en → req0_response at T+2, read_val=0xCAFEF00D, error=0; req1 outputs 0.
- Simultaneous: req0 write 0x20←0x11, req1 read 0x24, both held from reset → req0 granted first (prio=0), then req1; mem_addr sequence 0x20, 0x24.
- Fairness: both requesters continuously re-request 6 times → grant order 0,1,0,1,0,1; each response exactly one cycle.
- Timeout: TIMEOUT=4, memory never responds to req1 read → req1_response with error=1, read_val=0xDEADBEEF, 4 BUSY cycles after issue; next access proceeds normally.
- Read+write both set on req0, plus a slow memory (response after 5 cycles) → mem_write_en=1, mem_read_en=0, outputs stable across all BUSY cycles, response at M+1.
- Reset asserted in BUSY → all outputs 0 immediately (async), no response pulse after release, next request granted to req0 first.
